// File: rtl/unpatchifier_pkg.sv
// vit_pkg: shared types and default geometry for the patch-domain stages
// (patch extraction and its inverse, the unpatchifier).
//   pixel_t          : one packed RGB pixel word
//   unpatch_state_e  : unpatchifier FSM encoding, visible on its state port
//   VIT_* localparams: default image/patch geometry shared by both stages
package vit_pkg;

  localparam int unsigned VIT_CHANNEL_SIZE      = 8;
  localparam int unsigned VIT_NUM_CHANNELS      = 3;
  localparam int unsigned VIT_PIXEL_WIDTH       = VIT_CHANNEL_SIZE * VIT_NUM_CHANNELS;
  localparam int unsigned VIT_IMG_WIDTH         = 16;
  localparam int unsigned VIT_IMG_HEIGHT        = 16;
  localparam int unsigned VIT_PATCH_SIZE        = 4;
  localparam int unsigned VIT_PATCH_SIZE_LOG2   = 2;

  localparam int unsigned VIT_PATCHES_IN_ROW    = VIT_IMG_WIDTH / VIT_PATCH_SIZE;
  localparam int unsigned VIT_PATCHES_IN_COL    = VIT_IMG_HEIGHT / VIT_PATCH_SIZE;
  localparam int unsigned VIT_TOTAL_NUM_PATCHES = VIT_PATCHES_IN_ROW * VIT_PATCHES_IN_COL;
  localparam int unsigned VIT_PATCH_VECTOR_SIZE = VIT_PATCH_SIZE * VIT_PATCH_SIZE;

  typedef logic [VIT_PIXEL_WIDTH-1:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EMIT = 3'd2
  } unpatch_state_e;

endpackage

// File: rtl/unpatchifier_patch_addr_gen.sv
// patch_addr_gen: walks a frame in patch-major / pixel-within-patch-minor
// order and reports the image coordinate of the current element.
//   clk, reset : clock, synchronous active-high reset (counters to 0)
//   advance    : step to the next element (one accepted beat)
//   row, col   : image coordinate of the current element
//   last       : current element is the final one of the frame
// Counters wrap to 0 after the final element, so a new frame needs no clear.
module patch_addr_gen #(
  parameter int unsigned IMG_WIDTH       = vit_pkg::VIT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT      = vit_pkg::VIT_IMG_HEIGHT,
  parameter int unsigned PATCH_SIZE      = vit_pkg::VIT_PATCH_SIZE,
  parameter int unsigned PATCH_SIZE_LOG2 = vit_pkg::VIT_PATCH_SIZE_LOG2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          advance,
  output logic [$clog2(IMG_HEIGHT)-1:0] row,
  output logic [$clog2(IMG_WIDTH)-1:0]  col,
  output logic                          last
);

  localparam int unsigned PATCHES_IN_ROW    = IMG_WIDTH / PATCH_SIZE;
  localparam int unsigned PATCHES_IN_COL    = IMG_HEIGHT / PATCH_SIZE;
  localparam int unsigned PATCH_VECTOR_SIZE = PATCH_SIZE * PATCH_SIZE;
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned PR_W  = (PATCHES_IN_COL > 1) ? $clog2(PATCHES_IN_COL) : 1;
  localparam int unsigned PC_W  = (PATCHES_IN_ROW > 1) ? $clog2(PATCHES_IN_ROW) : 1;
  localparam int unsigned Q_W   = 2 * PATCH_SIZE_LOG2;

  // The linear patch index p is kept as (patch row, patch col) so that
  // p/PATCHES_IN_ROW and p%PATCHES_IN_ROW never need a divider, even when
  // PATCHES_IN_ROW is not a power of two.
  logic [PR_W-1:0] prow;
  logic [PC_W-1:0] pcol;
  logic [Q_W-1:0]  q;

  logic q_wrap;
  logic pcol_wrap;
  logic prow_wrap;

  assign q_wrap    = (q == Q_W'(PATCH_VECTOR_SIZE - 1));
  assign pcol_wrap = (pcol == PC_W'(PATCHES_IN_ROW - 1));
  assign prow_wrap = (prow == PR_W'(PATCHES_IN_COL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      prow <= '0;
      pcol <= '0;
      q    <= '0;
    end else if (advance) begin
      if (q_wrap) begin
        q <= '0;
        if (pcol_wrap) begin
          pcol <= '0;
          prow <= prow_wrap ? '0 : prow + PR_W'(1);
        end else begin
          pcol <= pcol + PC_W'(1);
        end
      end else begin
        q <= q + Q_W'(1);
      end
    end
  end

  // Upper half of q selects the row inside the patch, lower half the column.
  logic [PATCH_SIZE_LOG2-1:0] q_row;
  logic [PATCH_SIZE_LOG2-1:0] q_col;

  assign q_row = q[Q_W-1 -: PATCH_SIZE_LOG2];
  assign q_col = q[PATCH_SIZE_LOG2-1:0];

  assign row  = (ROW_W'(prow) << PATCH_SIZE_LOG2) | ROW_W'(q_row);
  assign col  = (COL_W'(pcol) << PATCH_SIZE_LOG2) | COL_W'(q_col);
  assign last = q_wrap && pcol_wrap && prow_wrap;

endmodule

// File: rtl/unpatchifier.sv
// unpatchifier: rebuilds an image from a stream of patch vectors and then
// streams it out in raster order.
//   clk, reset  : clock, synchronous active-high reset
//   en          : start request, sampled only in IDLE
//   in_valid/in_ready/in_pixel   : patch-vector input stream (ready in LOAD)
//   out_valid/out_ready/out_pixel: raster output stream (valid in EMIT)
//   out_row, out_col             : coordinate of out_pixel
//   out_last    : high with the final pixel of the frame
//   frame_done  : one-cycle pulse after the final output handshake
//   state       : current FSM state (IDLE=0, LOAD=1, EMIT=2)
module unpatchifier #(
  parameter int unsigned CHANNEL_SIZE    = vit_pkg::VIT_CHANNEL_SIZE,
  parameter int unsigned NUM_CHANNELS    = vit_pkg::VIT_NUM_CHANNELS,
  parameter int unsigned PIXEL_WIDTH     = CHANNEL_SIZE * NUM_CHANNELS,
  parameter int unsigned IMG_WIDTH       = vit_pkg::VIT_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT      = vit_pkg::VIT_IMG_HEIGHT,
  parameter int unsigned PATCH_SIZE      = vit_pkg::VIT_PATCH_SIZE,
  parameter int unsigned PATCH_SIZE_LOG2 = vit_pkg::VIT_PATCH_SIZE_LOG2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [PIXEL_WIDTH-1:0]        in_pixel,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PIXEL_WIDTH-1:0]        out_pixel,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          out_last,
  output logic                          frame_done,
  output logic [2:0]                    state
);

  import vit_pkg::*;

  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam int unsigned COL_W = $clog2(IMG_WIDTH);

  unpatch_state_e state_q;
  unpatch_state_e state_d;

  logic load;
  logic emit;
  logic in_hs;
  logic out_hs;

  assign load   = (state_q == LOAD);
  assign emit   = (state_q == EMIT);
  assign in_hs  = load && in_valid;
  assign out_hs = emit && out_ready;

  // Write side: patch-order address generation
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic             wr_last;

  patch_addr_gen #(
    .IMG_WIDTH       (IMG_WIDTH),
    .IMG_HEIGHT      (IMG_HEIGHT),
    .PATCH_SIZE      (PATCH_SIZE),
    .PATCH_SIZE_LOG2 (PATCH_SIZE_LOG2)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .advance (in_hs),
    .row     (wr_row),
    .col     (wr_col),
    .last    (wr_last)
  );

  // Frame buffer; contents deliberately not reset.
  logic [PIXEL_WIDTH-1:0] img [IMG_HEIGHT][IMG_WIDTH];

  always_ff @(posedge clk) begin
    if (in_hs) begin
      img[wr_row][wr_col] <= in_pixel;
    end
  end

  // Read side: raster counters
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_col_wrap;
  logic             rd_last;

  assign rd_col_wrap = (rd_col == COL_W'(IMG_WIDTH - 1));
  assign rd_last     = rd_col_wrap && (rd_row == ROW_W'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_row <= '0;
      rd_col <= '0;
    end else if (out_hs) begin
      if (rd_col_wrap) begin
        rd_col <= '0;
        rd_row <= rd_last ? '0 : rd_row + ROW_W'(1);
      end else begin
        rd_col <= rd_col + COL_W'(1);
      end
    end
  end

  // FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    if (in_hs && wr_last) state_d = EMIT;
      EMIT:    if (out_hs && rd_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_hs && rd_last;
    end
  end

  // Pixel is forced to zero outside EMIT so stale buffer data never leaks
  // onto the port while idle or loading.
  assign in_ready  = load;
  assign out_valid = emit;
  assign out_pixel = emit ? img[rd_row][rd_col] : '0;
  assign out_row   = rd_row;
  assign out_col   = rd_col;
  assign out_last  = emit && rd_last;
  assign state     = state_q;

endmodule

// File: tb/tb_unpatchifier.sv
module tb_unpatchifier;
  import vit_pkg::*;

  localparam int W    = 16;
  localparam int H    = 16;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pixel;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        out_last;
  logic        frame_done;
  logic [2:0]  state;

  always #5 clk = ~clk;

  unpatchifier #(
    .CHANNEL_SIZE    (8),
    .NUM_CHANNELS    (3),
    .PIXEL_WIDTH     (24),
    .IMG_WIDTH       (16),
    .IMG_HEIGHT      (16),
    .PATCH_SIZE      (4),
    .PATCH_SIZE_LOG2 (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .frame_done (frame_done),
    .state      (state)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [23:0] pix;
    logic [3:0]  row;
    logic [3:0]  col;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] model [H][W];
  logic [23:0] got   [H][W];

  // Drives beats base+k from the first LOAD cycle; caller raises en first.
  task automatic drive_frame(input logic [23:0] base, input bit bubbles,
                             input bit hold_en, input int nbeats);
    int k = 0;
    int waited = 0;
    bit started = 0;
    int p, q, r, c;
    while (k < nbeats) begin
      @(negedge clk);
      if (!started) begin
        if (in_ready === 1'b1) begin
          started = 1;
          if (!hold_en) en = 1'b0;
        end else begin
          in_valid = 1'b0;
          waited++;
          if (waited > 20) begin
            checks++; failures++;
            $display("FAIL load_start in_ready=%b required=1", in_ready);
            return;
          end
          continue;
        end
      end else begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL in_ready_during_load got=%b required=1 beat=%0d", in_ready, k);
        end
      end
      if (bubbles && ($urandom_range(1, 0) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_pixel = 24'(base + 24'(k));
        p = k / 16; q = k % 16;
        r = (p / 4) * 4 + q / 4;
        c = (p % 4) * 4 + q % 4;
        model[r][c] = in_pixel;
        k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (nbeats == NPIX) begin
      checks++;
      if (out_valid !== 1'b1 || state !== 3'd2) begin
        failures++;
        $display("FAIL first_out_latency out_valid=%b state=%0d required 1/2", out_valid, state);
      end
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        sb.push_back('{pix: model[r][c], row: 4'(r), col: 4'(c)});
  endtask

  // Consumes one frame from the DUT against the scoreboard.
  task automatic collect(input int stall_at, input int stall_len, input bit guard);
    int idx = 0;
    int stalled = 0;
    int cyc = 0;
    exp_t e;
    while (idx < NPIX) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000 || sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL collect_timeout idx=%0d queue=%0d required idx=%0d", idx, sb.size(), NPIX);
        out_ready = 1'b0;
        return;
      end
      e = sb[0];
      if (guard) begin
        checks++;
        if (in_ready !== 1'b0 || state !== 3'd2) begin
          failures++;
          $display("FAIL guard in_ready=%b state=%0d required 0/2", in_ready, state);
        end
        en = 1'b1; in_valid = 1'b1; in_pixel = 24'hFFFFFF;
      end
      if (idx == stall_at && stalled < stall_len) begin
        out_ready = 1'b0;
        stalled++;
        checks++;
        if (out_valid !== 1'b1 || out_pixel !== e.pix || out_row !== e.row || out_col !== e.col
            || out_last !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold pix=%h row=%0d col=%0d required pix=%h row=%0d col=%0d",
                   out_pixel, out_row, out_col, e.pix, e.row, e.col);
        end
        continue;
      end
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_pixel !== e.pix || out_row !== e.row || out_col !== e.col
          || out_last !== (idx == NPIX - 1)) begin
        failures++;
        $display("FAIL raster idx=%0d valid=%b pix=%h row=%0d col=%0d last=%b required pix=%h row=%0d col=%0d last=%b",
                 idx, out_valid, out_pixel, out_row, out_col, out_last,
                 e.pix, e.row, e.col, (idx == NPIX - 1));
      end
      got[out_row][out_col] = out_pixel;
      void'(sb.pop_front());
      idx++;
    end
    @(negedge clk);
    out_ready = 1'b0;
    if (guard) begin
      en = 1'b0; in_valid = 1'b0; in_pixel = '0;
    end
    checks++;
    if (frame_done !== 1'b1 || state !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL frame_done_pulse fd=%b state=%0d valid=%b required 1/0/0", frame_done, state, out_valid);
    end
  endtask

  task automatic run_frame(input logic [23:0] base, input bit bubbles,
                           input int stall_at, input int stall_len, input bit guard);
    @(negedge clk);
    en = 1'b1;
    drive_frame(base, bubbles, 1'b0, NPIX);
    push_frame();
    collect(stall_at, stall_len, guard);
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0 || state !== 3'd0) begin
      failures++;
      $display("FAIL after_frame fd=%b state=%0d required 0/0", frame_done, state);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (state !== 3'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0
        || frame_done !== 1'b0 || out_pixel !== 24'd0 || out_row !== 4'd0 || out_col !== 4'd0) begin
      failures++;
      $display("FAIL reset_state state=%0d rdy=%b vld=%b last=%b fd=%b pix=%h row=%0d col=%0d required all 0",
               state, in_ready, out_valid, out_last, frame_done, out_pixel, out_row, out_col);
    end
    reset = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (state !== 3'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold state=%0d in_ready=%b required 0/0", state, in_ready);
    end
  endtask

  task automatic check_ramp_points(input logic [23:0] base);
    checks++;
    if (got[0][0] !== 24'(base + 0) || got[0][1] !== 24'(base + 1) || got[1][0] !== 24'(base + 4)
        || got[0][4] !== 24'(base + 16) || got[4][0] !== 24'(base + 64)
        || got[15][15] !== 24'(base + 255)) begin
      failures++;
      $display("FAIL ramp_points got %h %h %h %h %h %h required base %h +0,1,4,16,64,255",
               got[0][0], got[0][1], got[1][0], got[0][4], got[4][0], got[15][15], base);
    end
  endtask

  task automatic test_ramp();
    run_frame(24'd0, 1'b0, -1, 0, 1'b0);
    check_ramp_points(24'd0);
  endtask

  task automatic test_bubbles();
    run_frame(24'd0, 1'b1, -1, 0, 1'b0);
    check_ramp_points(24'd0);
  endtask

  task automatic test_backpressure();
    run_frame(24'd0, 1'b0, 10, 3, 1'b0);
    checks++;
    if (got[0][10] !== 24'd34) begin
      failures++;
      $display("FAIL backpressure_pixel got=%h required=000022", got[0][10]);
    end
  endtask

  task automatic test_guards();
    run_frame(24'h000123, 1'b0, -1, 0, 1'b1);
    check_ramp_points(24'h000123);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk);
    en = 1'b1;
    drive_frame(24'h00ABCD, 1'b0, 1'b0, 100);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 3'd0 || in_ready !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0
        || out_pixel !== 24'd0) begin
      failures++;
      $display("FAIL reset_mid_load state=%0d rdy=%b vld=%b fd=%b pix=%h required 0",
               state, in_ready, out_valid, frame_done, out_pixel);
    end
    reset = 1'b0;
    run_frame(24'd0, 1'b0, -1, 0, 1'b0);
    check_ramp_points(24'd0);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    en = 1'b1;
    drive_frame(24'd0, 1'b0, 1'b1, NPIX);
    push_frame();
    collect(-1, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (state !== 3'd1 || frame_done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap state=%0d fd=%b required 1/0", state, frame_done);
    end
    drive_frame(24'd256, 1'b0, 1'b1, NPIX);
    en = 1'b0;
    push_frame();
    collect(-1, 0, 1'b0);
    checks++;
    if (got[0][0] !== 24'd256 || got[15][15] !== 24'd511) begin
      failures++;
      $display("FAIL b2b_second got (0,0)=%h (15,15)=%h required 000100/0001ff", got[0][0], got[15][15]);
    end
    @(negedge clk);
    checks++;
    if (state !== 3'd0) begin
      failures++;
      $display("FAIL b2b_end state=%0d required 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_bubbles();
    test_backpressure();
    test_guards();
    test_reset_mid_load();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpatchifier.md
Name: unpatchifier

Overview:
- Inverse of the patch-extraction stage: accepts a frame as a stream of patch vectors (patch-major, pixel-within-patch minor) and rebuilds the image in an internal buffer.
- Then streams the image out in raster order over a valid/ready interface.
- Sits after the patch-domain datapath (post-attention reconstruction / debug readback) and before any pixel-domain consumer.

Parameters:
CHANNEL_SIZE, 8, bits per colour channel
NUM_CHANNELS, 3, channels per pixel (RGB)
PIXEL_WIDTH, CHANNEL_SIZE*NUM_CHANNELS, pixel word width
IMG_WIDTH, 16, image columns; multiple of PATCH_SIZE
IMG_HEIGHT, 16, image rows; multiple of PATCH_SIZE
PATCH_SIZE, 4, patch edge in pixels; power of two
PATCH_SIZE_LOG2, 2, log2(PATCH_SIZE)
Derived localparams: PATCHES_IN_ROW=IMG_WIDTH/PATCH_SIZE, TOTAL_NUM_PATCHES=(IMG_WIDTH/PATCH_SIZE)*(IMG_HEIGHT/PATCH_SIZE), PATCH_VECTOR_SIZE=PATCH_SIZE*PATCH_SIZE.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
en  input  1  start request; sampled only in IDLE
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid&&in_ready
in_pixel  input  PIXEL_WIDTH  patch-vector element
out_valid  output  1  raster pixel valid
out_ready  input  1  consumer accepts
out_pixel  output  PIXEL_WIDTH  raster pixel
out_row  output  $clog2(IMG_HEIGHT)  row of out_pixel
out_col  output  $clog2(IMG_WIDTH)  column of out_pixel
out_last  output  1  high with final pixel (row H-1, col W-1)
frame_done  output  1  one-cycle pulse after final output handshake
state  output  3  current FSM state (IDLE=0, LOAD=1, EMIT=2)

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset (also mid-operation):
  - state=IDLE; counters cleared.
  - in_ready=0, out_valid=0, out_last=0, frame_done=0, out_pixel/out_row/out_col=0.
  - Buffer contents not cleared (don't-care). Any partial frame is abandoned.
- IDLE:
  - in_ready=0, out_valid=0.
  - en=1 -> LOAD next cycle. in_valid is ignored.
- LOAD:
  - in_ready=1 (decoded from the state register).
  - Beat k = p*PATCH_VECTOR_SIZE + q.
  - Row = (p/PATCHES_IN_ROW)*PATCH_SIZE + (q>>PATCH_SIZE_LOG2).
  - Col = (p%PATCHES_IN_ROW)*PATCH_SIZE + (q&(PATCH_SIZE-1)).
  - Each accepted beat writes buf[row][col]. Counters advance only on handshake; input bubbles are allowed.
  - Handshake with p=TOTAL_NUM_PATCHES-1 and q=PATCH_VECTOR_SIZE-1 -> EMIT next cycle.
  - in_ready drops in that same next cycle.
- EMIT:
  - out_valid=1. out_pixel=buf[out_row][out_col] (combinational read of the registered buffer).
  - Raster order: col increments, wraps to 0 with row+1.
  - out_ready=0 holds out_pixel/out_row/out_col/out_last stable.
  - out_last=1 only at (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Handshake on the last pixel -> IDLE next cycle, frame_done=1 for exactly that cycle, read counters wrap to 0.
- Latency:
  - First out_valid occurs 1 cycle after the last input handshake.
  - With no backpressure: IMG_WIDTH*IMG_HEIGHT output cycles.
- Back-to-back frames: en held high -> LOAD entered the cycle after returning to IDLE. Minimum gap is 1 IDLE cycle.
- en in LOAD/EMIT is ignored, not queued.
- Counter widths sized by $clog2 of their limits. No arithmetic overflow is possible; all index math is shifts/masks when PATCH_SIZE is a power of two.
- Buffer is never partially stale within a frame: every location is written once per LOAD.

Decomposition:
- Package vit_pkg:
  - pixel_t (logic [PIXEL_WIDTH-1:0])
  - unpatch_state_e enum (IDLE, LOAD, EMIT; 3-bit)
  - derived patch geometry localparams shared with the patch-extraction stage
- Sub-module patch_addr_gen: patch/position counters with advance input; outputs row, col and last-beat flag. Reusable by the forward patch stage.

Test Plan:
- Ramp, no stalls: in_pixel=k for k=0..255 -> out(0,0)=0, (0,1)=1, (1,0)=4, (0,4)=16, (4,0)=64, (15,15)=255. out_last only on beat 256; frame_done pulses once the cycle after.
- Input bubbles: in_valid 50% random over ramp -> identical 256-pixel output sequence; in_ready stays 1 throughout LOAD.
- Output backpressure: out_ready=0 for 3 cycles at raster beat 10 (row 0, col 10, expected 34) -> out_pixel=34, out_row=0, out_col=10 held for 3 cycles; no skipped or duplicated pixel.
- Protocol guards: en pulsed and in_valid=1 with in_pixel=FFFFFF during EMIT -> in_ready=0, state unchanged, output sequence unaffected.
- Reset mid-LOAD after 100 beats -> next cycle state=0, in_ready=0, out_valid=0. Fresh ramp frame then reproduces the first scenario exactly.
- Back-to-back: en held 1, two ramp frames (second offset +256 mod 2^24) -> second frame's (0,0)=256, (15,15)=511; exactly one IDLE cycle between frames.
